// File: rtl/add_and_eq_ops.sv
// Registered ADD / AND / EQ unit with full-word or half-word operand width.
// One result per accepted operation, one cycle after the sampling edge.
module add_and_eq_ops #(
    parameter int WIDTH = 20,
    parameter int HALF  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] c,
    output logic             zero
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_EQ  = 2'b10;

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] am;
    logic [WIDTH-1:0] bm;
    logic [WIDTH-1:0] res;
    logic             res_zero;
    logic             take;

    // Masking both operands and the sum drops every bit above the active width,
    // which also discards the carry-out.
    always_comb begin
        mask     = mode ? {WIDTH{1'b1}}
                        : {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};
        am       = a & mask;
        bm       = b & mask;
        res      = '0;
        res_zero = 1'b0;
        case (op)
            OP_ADD: begin
                res      = (am + bm) & mask;
                res_zero = (res == '0);
            end
            OP_AND: begin
                res      = am & bm;
                res_zero = (res == '0);
            end
            OP_EQ: begin
                res      = '0;
                res_zero = (am == bm);
            end
            default: begin
                res      = '0;
                res_zero = 1'b0;
            end
        endcase
    end

    assign take = in_valid && (op != 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
            zero      <= 1'b0;
        end else begin
            out_valid <= take;
            if (take) begin
                c    <= res;
                zero <= res_zero;
            end
        end
    end

endmodule

// File: tb/tb_add_and_eq_ops.sv
// Self-checking bench for add_and_eq_ops: directed cases, reset cases and
// randomized traffic against an arithmetic reference model.
module tb_add_and_eq_ops;

    localparam int WIDTH = 20;
    localparam int HALF  = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [1:0]       op;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] c;
    logic             zero;

    int compared   = 0;
    int mismatched = 0;

    longint unsigned exp_c;
    logic            exp_zero;
    logic            exp_valid;

    add_and_eq_ops #(.WIDTH(WIDTH), .HALF(HALF)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .op(op),
        .mode(mode),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .c(c),
        .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint unsigned obs,
                       input longint unsigned expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: result computed modulo 2^active with plain arithmetic.
    task automatic model(input logic v, input logic [1:0] o, input logic md,
                         input longint unsigned av, input longint unsigned bv);
        longint unsigned m;
        longint unsigned am;
        longint unsigned bm;
        m  = 64'd1 << (md ? WIDTH : HALF);
        am = av % m;
        bm = bv % m;
        if (!v || o == 2'd3) begin
            exp_valid = 1'b0;
        end else begin
            exp_valid = 1'b1;
            if (o == 2'd0) begin
                exp_c    = (am + bm) % m;
                exp_zero = (exp_c == 0);
            end else if (o == 2'd1) begin
                exp_c    = am & bm;
                exp_zero = (exp_c == 0);
            end else begin
                exp_c    = 0;
                exp_zero = (am == bm);
            end
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [1:0] o,
                        input logic md, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv);
        @(negedge clk);
        in_valid = v;
        op       = o;
        mode     = md;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        model(v, o, md, av, bv);
        chk({tag, "_valid"}, out_valid, exp_valid);
        chk({tag, "_c"}, c, exp_c);
        chk({tag, "_zero"}, zero, exp_zero);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = 2'b00;
        mode     = 1'b0;
        a        = '0;
        b        = '0;
        exp_c    = 0;
        exp_zero = 1'b0;
        exp_valid = 1'b0;

        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_c", c, 0);
        chk("rst_zero", zero, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_c", c, 0);
        @(negedge clk);
        rst_n = 1'b1;

        step("r030", 1, 2'b00, 1, 20'hFFFFF, 20'h00001);
        chk("r030_c_const", c, 20'h00000);
        chk("r030_z_const", zero, 1);
        step("r031h", 1, 2'b00, 0, 20'h123FF, 20'h00001);
        chk("r031h_c_const", c, 20'h00000);
        step("r031f", 1, 2'b00, 1, 20'h123FF, 20'h00001);
        chk("r031f_c_const", c, 20'h12400);
        chk("r031f_z_const", zero, 0);
        step("r032h", 1, 2'b01, 0, 20'hFFC00, 20'hFFFFF);
        chk("r032h_c_const", c, 20'h00000);
        chk("r032h_z_const", zero, 1);
        step("r033h", 1, 2'b10, 0, 20'h55155, 20'hAA155);
        chk("r033h_z_const", zero, 1);
        step("r033f", 1, 2'b10, 1, 20'h55155, 20'hAA155);
        chk("r033f_z_const", zero, 0);
        step("r032f", 1, 2'b01, 1, 20'hF0F0F, 20'h0FF0F);
        chk("r032f_c_const", c, 20'h00F0F);
        step("r034op", 1, 2'b11, 1, 20'h00000, 20'h00000);
        chk("r034op_c_const", c, 20'h00F0F);
        chk("r034op_v_const", out_valid, 0);
        step("r034iv", 0, 2'b00, 1, 20'h00000, 20'h00000);
        chk("r034iv_c_const", c, 20'h00F0F);
        step("ext_h", 1, 2'b00, 0, 20'hFFFFF, 20'hFFFFF);
        chk("ext_h_c_const", c, 20'h003FE);
        step("ext_and", 1, 2'b01, 1, 20'hFFFFF, 20'hFFFFF);

        // Reset asserted mid-cycle while a valid ADD is presented.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 2'b00;
        mode     = 1'b1;
        a        = 20'h00010;
        b        = 20'h00020;
        #2;
        rst_n = 1'b0;
        #1;
        chk("r035_imm_c", c, 0);
        chk("r035_imm_zero", zero, 0);
        chk("r035_imm_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("r035_edge_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        exp_c    = 0;
        exp_zero = 1'b0;
        @(posedge clk);
        #1;
        chk("r035_post_valid", out_valid, 0);
        chk("r035_post_c", c, 0);
        chk("r035_post_zero", zero, 0);

        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rv;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if ($urandom_range(0, 7) == 0) ra = '1;
            if ($urandom_range(0, 7) == 0) rb = '1;
            if ($urandom_range(0, 9) == 0) rb = ra;
            rv = ($urandom_range(0, 4) != 0);
            step("rand", rv, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
